// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM state type and lane-select helpers for the LSU stage.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        GAP,
        STORE,
        WB,
        FAULT
    } lsu_state_e;

    function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] sel);
        return w[{sel, 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] half_lane(input logic [31:0] w, input logic sel);
        return sel ? w[31:16] : w[15:0];
    endfunction

    // Funct3[1:0] carries the access size: 00 byte, 01 half, 1x word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: request/response bus between the LSU stage (master) and the data-cache controller.
interface lsu_mem_stage_if;
    logic        read_mem;
    logic        write_mem;
    logic [31:0] addr;
    logic        addr_valid;
    logic [31:0] write_data;
    logic        write_data_valid;
    logic        mem_done;
    logic [31:0] result;

    modport master (
        output read_mem, write_mem, addr, addr_valid, write_data, write_data_valid,
        input  mem_done, result
    );

    modport slave (
        input  read_mem, write_mem, addr, addr_valid, write_data, write_data_valid,
        output mem_done, result
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational load extract/extend and sub-word store merge into a captured word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  ea_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] sdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = byte_lane(word, ea_lo);
    assign sel_half = half_lane(word, ea_lo[1]);

    always_comb begin
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = word;
        endcase
    end

    // Half-word lane follows ea[1] only, so a misaligned SH lands on its natural lane.
    always_comb begin
        store_word = sdata;
        case (funct3[1:0])
            2'b00: begin
                store_word = word;
                store_word[{ea_lo, 3'b000} +: 8] = sdata[7:0];
            end
            2'b01: begin
                store_word = word;
                if (ea_lo[1]) store_word[31:16] = sdata[15:0];
                else          store_word[15:0]  = sdata[15:0];
            end
            default: store_word = sdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: issues one load/store to the cache controller, with RMW for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of truncating them.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic            issue_is_store,
    input  logic [2:0]      issue_funct3,
    input  logic [31:0]     issue_base,
    input  logic [31:0]     issue_offset,
    input  logic [31:0]     issue_sdata,
    input  logic [4:0]      issue_rd,
    lsu_mem_stage_if.master mem,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [31:0]     wb_data,
    output logic            st_done,
    output logic            lsu_fault,
    output logic [31:0]     fault_addr
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state, state_next;
    logic [31:0] ea, ea_q, sdata_q, word_q, fault_addr_q;
    logic [31:0] load_data, store_word;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [CW-1:0] tmo_cnt;
    logic        tmo_hit, misalign;

    assign ea      = issue_base + issue_offset;
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(issue_funct3, ea[1:0]);
`else
    assign misalign = 1'b0;
`endif

    lsu_align u_align (
        .word       (word_q),
        .ea_lo      (ea_q[1:0]),
        .funct3     (f3_q),
        .sdata      (sdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ea_q         <= '0;
            sdata_q      <= '0;
            word_q       <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            tmo_cnt      <= '0;
            fault_addr_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && issue_valid) begin
                ea_q    <= ea;
                f3_q    <= issue_funct3;
                rd_q    <= issue_rd;
                sdata_q <= issue_sdata;
            end
            if ((state == LOAD || state == RMW_RD) && mem.mem_done)
                word_q <= mem.result;
            // Counter restarts on every state change, so each request phase gets a full budget.
            if (state_next != state)
                tmo_cnt <= '0;
            else if (state == LOAD || state == RMW_RD || state == STORE)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (state_next == FAULT && state != FAULT)
                fault_addr_q <= (state == IDLE) ? ea : ea_q;
        end
    end

    always_comb begin
        state_next     = state;
        issue_ready    = 1'b0;
        mem.read_mem   = 1'b0;
        mem.write_mem  = 1'b0;
        mem.write_data = '0;
        wb_valid       = 1'b0;
        st_done        = 1'b0;
        lsu_fault      = 1'b0;
        case (state)
            IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    if (misalign)            state_next = FAULT;
                    else if (!issue_is_store) state_next = LOAD;
                    else if (issue_funct3[1]) state_next = STORE;
                    else                      state_next = RMW_RD;
                end
            end
            LOAD: begin
                mem.read_mem = 1'b1;
                if (mem.mem_done)  state_next = WB;
                else if (tmo_hit)  state_next = FAULT;
            end
            RMW_RD: begin
                mem.read_mem = 1'b1;
                if (mem.mem_done)  state_next = GAP;
                else if (tmo_hit)  state_next = FAULT;
            end
            GAP: state_next = STORE;
            STORE: begin
                mem.write_mem  = 1'b1;
                mem.write_data = store_word;
                if (mem.mem_done) begin
                    st_done    = 1'b1;
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    state_next = FAULT;
                end
            end
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready) state_next = IDLE;
            end
            FAULT: begin
                lsu_fault  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem.addr             = {ea_q[31:2], 2'b00};
    assign mem.addr_valid       = mem.read_mem | mem.write_mem;
    assign mem.write_data_valid = mem.write_mem;
    assign wb_rd                = wb_valid ? rd_q : '0;
    assign wb_data              = wb_valid ? load_data : '0;
    assign fault_addr           = fault_addr_q;

endmodule
